// File: rtl/timer_capture_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_capture_fifo_if
//  Description : Bundles the capture input, the flush control, the readout
//                stream and the status outputs of timer_capture_fifo.
//                slave  : FIFO side (takes captures, drives the stream).
//                master : timer/host side (drives captures, consumes stream).
//                Optional TIMER_CAPFIFO_DELTA_EN adds out_delta/out_first.
//  Revision    : 1.0 - initial release
// ============================================================================
interface timer_capture_fifo_if #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8
) ();
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              cap_valid;
    logic [WIDTH-1:0]  cap_value;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [LVL_W-1:0]  level;
    logic              full;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;
`ifdef TIMER_CAPFIFO_DELTA_EN
    logic [WIDTH-1:0]  out_delta;
    logic              out_first;

    modport slave (
        input  cap_valid, cap_value, flush, out_ready,
        output out_valid, out_data, level, full, overflow, drop_count,
               out_delta, out_first
    );
    modport master (
        output cap_valid, cap_value, flush, out_ready,
        input  out_valid, out_data, level, full, overflow, drop_count,
               out_delta, out_first
    );
`else
    modport slave (
        input  cap_valid, cap_value, flush, out_ready,
        output out_valid, out_data, level, full, overflow, drop_count
    );
    modport master (
        output cap_valid, cap_value, flush, out_ready,
        input  out_valid, out_data, level, full, overflow, drop_count
    );
`endif
endinterface
`default_nettype wire

// File: rtl/timer_capture_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : timer_capture_fifo
//  Description : First-word-fall-through FIFO buffering timer capture values,
//                with sticky overflow flag and saturating dropped-capture
//                counter. All stream/status outputs are registered.
//  Ports       : clk    - system clock (rising edge)
//                sreset - synchronous active-high reset
//                bus    - timer_capture_fifo_if.slave (capture input, flush,
//                         out_valid/out_ready/out_data stream, level, full,
//                         overflow, drop_count)
//  Options     : `define TIMER_CAPFIFO_DELTA_EN to store per-entry delta to
//                the previous accepted capture (out_delta) and a first flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_capture_fifo #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8
) (
    input  wire logic             clk,
    input  wire logic             sreset,
    timer_capture_fifo_if.slave   bus
);
    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               LVL_W   = PTR_W + 1;
    localparam logic [LVL_W-1:0] C_DEPTH = LVL_W'(DEPTH);

    logic [WIDTH-1:0]  r_mem_q [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr_q,   r_wr_ptr_d;
    logic [PTR_W-1:0]  r_rd_ptr_q,   r_rd_ptr_d;
    logic [LVL_W-1:0]  r_level_q,    r_level_d;
    logic              r_out_valid_q, r_out_valid_d;
    logic [WIDTH-1:0]  r_out_data_q, r_out_data_d;
    logic              r_full_q,     r_full_d;
    logic              r_overflow_q, r_overflow_d;
    logic [DROP_W-1:0] r_drop_q,     r_drop_d;

    logic w_pop, w_push, w_drop, w_we, w_head_is_new;

`ifdef TIMER_CAPFIFO_DELTA_EN
    logic [WIDTH-1:0] r_dmem_q [DEPTH];
    logic             r_fmem_q [DEPTH];
    logic [WIDTH-1:0] r_prev_q,      r_prev_d;
    logic             r_have_prev_q, r_have_prev_d;
    logic [WIDTH-1:0] r_out_delta_q, r_out_delta_d;
    logic             r_out_first_q, r_out_first_d;
    logic [WIDTH-1:0] w_delta_in;
    logic             w_first_in;
`endif

    always_comb begin
        w_pop  = r_out_valid_q & bus.out_ready;
        // A full FIFO still accepts a capture when the head leaves this cycle.
        w_push = bus.cap_valid & ((r_level_q != C_DEPTH) | w_pop);
        w_drop = bus.cap_valid & (r_level_q == C_DEPTH) & ~w_pop;
        w_we   = w_push & ~bus.flush;

        r_wr_ptr_d   = r_wr_ptr_q;
        r_rd_ptr_d   = r_rd_ptr_q;
        r_level_d    = r_level_q;
        r_overflow_d = r_overflow_q;
        r_drop_d     = r_drop_q;

        if (bus.flush) begin
            r_wr_ptr_d   = '0;
            r_rd_ptr_d   = '0;
            r_level_d    = '0;
            r_overflow_d = 1'b0;
            r_drop_d     = '0;
        end else begin
            if (w_push) r_wr_ptr_d = r_wr_ptr_q + PTR_W'(1);
            if (w_pop)  r_rd_ptr_d = r_rd_ptr_q + PTR_W'(1);
            if (w_push && !w_pop)      r_level_d = r_level_q + LVL_W'(1);
            else if (!w_push && w_pop) r_level_d = r_level_q - LVL_W'(1);
            if (w_drop) begin
                r_overflow_d = 1'b1;
                if (r_drop_q != '1) r_drop_d = r_drop_q + DROP_W'(1);
            end
        end

        // The next head is the entry being written this cycle only when the
        // new read pointer lands on the current write slot (FIFO held 0 or 1
        // entry); a full FIFO writing here must be popping, so no alias.
        w_head_is_new = w_we && (r_rd_ptr_d == r_wr_ptr_q);
        r_full_d      = (r_level_d == C_DEPTH);
        r_out_valid_d = (r_level_d != '0);
        if (r_level_d == '0)    r_out_data_d = '0;
        else if (w_head_is_new) r_out_data_d = bus.cap_value;
        else                    r_out_data_d = r_mem_q[r_rd_ptr_d];

`ifdef TIMER_CAPFIFO_DELTA_EN
        w_first_in    = ~r_have_prev_q;
        w_delta_in    = r_have_prev_q ? (bus.cap_value - r_prev_q) : '0;
        r_prev_d      = r_prev_q;
        r_have_prev_d = r_have_prev_q;
        if (bus.flush) begin
            r_prev_d      = '0;
            r_have_prev_d = 1'b0;
        end else if (w_push) begin
            // Only accepted captures become the reference for the next delta.
            r_prev_d      = bus.cap_value;
            r_have_prev_d = 1'b1;
        end
        if (r_level_d == '0) begin
            r_out_delta_d = '0;
            r_out_first_d = 1'b0;
        end else if (w_head_is_new) begin
            r_out_delta_d = w_delta_in;
            r_out_first_d = w_first_in;
        end else begin
            r_out_delta_d = r_dmem_q[r_rd_ptr_d];
            r_out_first_d = r_fmem_q[r_rd_ptr_d];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem_q[r_wr_ptr_q] <= bus.cap_value;
`ifdef TIMER_CAPFIFO_DELTA_EN
            r_dmem_q[r_wr_ptr_q] <= w_delta_in;
            r_fmem_q[r_wr_ptr_q] <= w_first_in;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            r_wr_ptr_q    <= '0;
            r_rd_ptr_q    <= '0;
            r_level_q     <= '0;
            r_out_valid_q <= 1'b0;
            r_out_data_q  <= '0;
            r_full_q      <= 1'b0;
            r_overflow_q  <= 1'b0;
            r_drop_q      <= '0;
        end else begin
            r_wr_ptr_q    <= r_wr_ptr_d;
            r_rd_ptr_q    <= r_rd_ptr_d;
            r_level_q     <= r_level_d;
            r_out_valid_q <= r_out_valid_d;
            r_out_data_q  <= r_out_data_d;
            r_full_q      <= r_full_d;
            r_overflow_q  <= r_overflow_d;
            r_drop_q      <= r_drop_d;
        end
    end

`ifdef TIMER_CAPFIFO_DELTA_EN
    always_ff @(posedge clk) begin
        if (sreset) begin
            r_prev_q      <= '0;
            r_have_prev_q <= 1'b0;
            r_out_delta_q <= '0;
            r_out_first_q <= 1'b0;
        end else begin
            r_prev_q      <= r_prev_d;
            r_have_prev_q <= r_have_prev_d;
            r_out_delta_q <= r_out_delta_d;
            r_out_first_q <= r_out_first_d;
        end
    end

    assign bus.out_delta = r_out_delta_q;
    assign bus.out_first = r_out_first_q;
`endif

    assign bus.out_valid  = r_out_valid_q;
    assign bus.out_data   = r_out_data_q;
    assign bus.level      = r_level_q;
    assign bus.full       = r_full_q;
    assign bus.overflow   = r_overflow_q;
    assign bus.drop_count = r_drop_q;

endmodule
`default_nettype wire

// File: doc/timer_capture_fifo.md
Name: timer_capture_fifo

Overview:
- Downstream consumer of the timer block: buffers each captured count the timer produces.
- Presents captured counts to software or a host interface through a valid/ready stream.
- Reports overflow and a dropped-capture count so captures lost under back-pressure are visible.
- Sits directly between the timer capture output and the register/readout logic.

Parameters:
- WIDTH, 16, bit width of a captured timer value.
- DEPTH, 8, FIFO entries; must be a power of two and at least 2.
- DROP_W, 8, width of the saturating dropped-capture counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- sreset  in  1  synchronous active-high reset.
- cap_valid  in  1  one-cycle strobe from the timer: a new capture is present.
- cap_value  in  WIDTH  captured count; sampled when cap_valid=1.
- flush  in  1  synchronous clear of FIFO contents and status; driven from the rst_capture path.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  WIDTH  head entry value (first-word-fall-through).
- level  out  $clog2(DEPTH)+1  number of stored entries.
- full  out  1  level==DEPTH.
- overflow  out  1  sticky: at least one capture was dropped.
- drop_count  out  DROP_W  number of dropped captures, saturating at all-ones.

Behaviour:
- Reset (sreset=1):
  - level=0, out_valid=0, out_data=0, full=0, overflow=0, drop_count=0.
  - Read and write pointers return to 0.
  - The sreset value dominates all other inputs.
- Flush:
  - flush=1 has the same effect as sreset on FIFO state and status.
  - Flush has priority over a push or pop in the same cycle; a cap_valid in the flush cycle is discarded and not counted as dropped.
- Push:
  - On cap_valid=1, cap_value is written when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle.
- Drop:
  - When cap_valid=1, level==DEPTH and no pop occurs, the value is discarded.
  - overflow is set to 1.
  - drop_count increments unless it is already all-ones.
- Pop:
  - Occurs when out_valid=1 and out_ready=1; the read pointer advances.
  - out_ready while out_valid=0 has no effect.
- Latency:
  - A push into an empty FIFO gives out_valid=1 on the next cycle, with out_data equal to the pushed value.
  - out_data holds 0 while empty.
- Simultaneous push and pop:
  - level is unchanged; ordering is preserved.
  - When empty, a pop cannot occur; the push proceeds normally.
- Stream stability: out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- Pointers:
  - $clog2(DEPTH)-bit pointers wrap modulo DEPTH.
  - level is maintained as a counter that changes by +1, -1 or 0 per cycle.
- Sticky status: overflow and drop_count are cleared only by sreset or flush; popping does not clear them.
- Registered outputs: level, full, out_valid and out_data are registered outputs.

Optional Feature:
- Macro: TIMER_CAPFIFO_DELTA_EN.
- With the macro defined:
  - Adds output out_delta (WIDTH) and output out_first (1).
  - Each pushed entry also stores delta = (cap_value - prev_value) mod 2^WIDTH, where prev_value is the last accepted capture.
  - The first capture accepted after sreset or flush stores delta=0 and first=1.
  - A dropped capture does not update prev_value.
  - Both fields travel with out_data through the FIFO.
- Without the macro: these ports and storage do not exist; behaviour is otherwise identical.

Test Plan (DEPTH=4, WIDTH=16):
- Reset with cap_valid=1 and cap_value=0x1234 held during sreset -> all outputs 0 after release; no entry stored.
- Push 0x0064, out_ready=1 -> out_valid=1 exactly one cycle later with out_data=0x0064; level returns to 0 after the pop.
- out_ready=0, push 0x0010, 0x0020, 0x0030, 0x0040, 0x0050 -> full=1, level=4, overflow=1, drop_count=1; pops return 0x0010..0x0040 in order.
- FIFO full with cap_valid=1 and out_ready=1 in the same cycle -> no drop, level stays 4, the new value appears last.
- Three captures stored, then flush=1 with cap_valid=1 in the same cycle -> level=0, overflow=0, drop_count=0, out_valid=0 next cycle.
- DELTA_EN, captures 0xFFF0 then 0x0010 -> first entry delta=0 with first=1; second entry delta=0x0020 (wrap-around) with first=0.
